disp_arbiter: RTL and testbench

//  Shares the single 8-digit seven-segment display datapath (digits[7:0][3:0] + flt_pt[7:0]) between

---
 rtl/disp_arbiter_pkg.sv | 17 +
 rtl/disp_arbiter_rr_pick.sv | 35 +++
 rtl/disp_arbiter.sv | 139 +++++++++++++
 tb/tb_disp_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_arbiter_pkg.sv
// disp_pkg: shared types for the display arbiter and its helpers.
//   digits_t     - eight BCD/hex nibbles as driven into seven_seg.digits
//   darb_state_t - arbiter FSM states
//   DIG_BLANK    - all-zero digit word driven while nobody owns the display
package disp_pkg;

  typedef logic [7:0][3:0] digits_t;

  typedef enum logic [1:0] {
    IDLE,
    OWN,
    BLANK
  } darb_state_t;

  localparam digits_t DIG_BLANK = '0;

endpackage

// File: rtl/disp_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
// Searches req starting one position after 'last' (wrapping modulo N) and
// returns the first set bit.
//   req   in  N   request vector
//   last  in  IW  index of the previous winner
//   valid out 1   at least one request is set
//   idx   out IW  index of the winner (0 when valid is low)
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          valid,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] cand;

  // Offset N wraps back onto 'last' itself, so a lone requester that just
  // owned the display can still be re-picked.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = 1; i <= N; i++) begin
      cand = IW'((int'(last) + i) % N);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/disp_arbiter.sv
// disp_arbiter: shares the 8-digit seven-segment datapath between NSRC
// requesters with round-robin grant, a minimum hold time per owner and a
// blank gap on every hand-over.
//   CLK        in   system clock
//   NRST       in   synchronous reset, active low
//   req        in   per-source level request
//   src_digits in   per-source digit nibbles
//   src_flt_pt in   per-source decimal points
//   grant      out  one-hot owner (zero when none), registered
//   digits     out  digits for seven_seg, registered
//   flt_pt     out  decimal points for seven_seg, registered
//   disp_on    out  high while digits carry owner data
module disp_arbiter
  import disp_pkg::*;
#(
  parameter int NSRC        = 4,
  parameter int HOLD_TICKS  = 100,
  parameter int BLANK_TICKS = 5,
  parameter int CW          = 8
) (
  input  logic                       CLK,
  input  logic                       NRST,
  input  logic [NSRC-1:0]            req,
  input  logic [NSRC-1:0][7:0][3:0]  src_digits,
  input  logic [NSRC-1:0][7:0]       src_flt_pt,
  output logic [NSRC-1:0]            grant,
  output logic [7:0][3:0]            digits,
  output logic [7:0]                 flt_pt,
  output logic                       disp_on
);

  localparam int            IW        = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam logic [IW-1:0] LAST_RST  = IW'(NSRC - 1);
  localparam logic [CW-1:0] HOLD_C    = CW'(HOLD_TICKS);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_TICKS - 1);

  darb_state_t   state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [IW-1:0] last, last_next;
  logic [NSRC-1:0] grant_next;
  logic [NSRC-1:0] owner_mask;
  logic          owner_req;
  logic          others_req;
  logic          pick_valid;
  logic [IW-1:0] pick_idx;

  rr_pick #(
    .N  (NSRC),
    .IW (IW)
  ) u_pick (
    .req   (req),
    .last  (last),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // With a single source others_req is constantly zero, so preemption
  // can never fire.
  assign owner_mask = NSRC'(1) << last;
  assign owner_req  = req[last];
  assign others_req = |(req & ~owner_mask);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    last_next  = last;
    grant_next = grant;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_next = OWN;
          grant_next = NSRC'(1) << pick_idx;
          last_next  = pick_idx;
          cnt_next   = '0;
        end
      end
      OWN: begin
        // Voluntary release ignores the hold time; both causes in one cycle
        // still give a single BLANK entry.
        if (!owner_req || (cnt == HOLD_C && others_req)) begin
          state_next = BLANK;
          grant_next = '0;
          cnt_next   = '0;
        end else if (cnt != HOLD_C) begin
          cnt_next = cnt + 1'b1;
        end
      end
      BLANK: begin
        grant_next = '0;
        if (cnt == BLANK_END) begin
          cnt_next = '0;
          if (pick_valid) begin
            state_next = OWN;
            grant_next = NSRC'(1) << pick_idx;
            last_next  = pick_idx;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
        cnt_next   = '0;
      end
    endcase
  end

  // Digits and disp_on are registered from the current state so that they
  // rise one cycle after grant and always stay aligned with each other.
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      state   <= IDLE;
      cnt     <= '0;
      last    <= LAST_RST;
      grant   <= '0;
      digits  <= DIG_BLANK;
      flt_pt  <= '0;
      disp_on <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      last  <= last_next;
      grant <= grant_next;
      if (state == OWN) begin
        digits  <= src_digits[last];
        flt_pt  <= src_flt_pt[last];
        disp_on <= 1'b1;
      end else begin
        digits  <= DIG_BLANK;
        flt_pt  <= '0;
        disp_on <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_disp_arbiter.sv
// tb_disp_arbiter: self-checking bench for disp_arbiter with NSRC=4,
// HOLD_TICKS=4, BLANK_TICKS=2. Each scenario task pushes the owners it
// expects onto a scoreboard; a monitor pops one entry per new grant and
// checks the owner's data one cycle later, alongside invariant checks.
module tb_disp_arbiter;

  localparam int NSRC = 4;

  typedef struct {
    logic [3:0]  grant;
    logic [31:0] digits;
    logic [7:0]  flt;
  } exp_t;

  logic                 CLK = 1'b0;
  logic                 NRST;
  logic [3:0]           req;
  logic [3:0][7:0][3:0] src_digits;
  logic [3:0][7:0]      src_flt_pt;
  logic [3:0]           grant;
  logic [7:0][3:0]      digits;
  logic [7:0]           flt_pt;
  logic                 disp_on;

  int   checks = 0;
  int   passed = 0;
  exp_t sb[$];

  always #5 CLK = ~CLK;

  disp_arbiter #(
    .NSRC        (NSRC),
    .HOLD_TICKS  (4),
    .BLANK_TICKS (2),
    .CW          (8)
  ) dut (
    .CLK        (CLK),
    .NRST       (NRST),
    .req        (req),
    .src_digits (src_digits),
    .src_flt_pt (src_flt_pt),
    .grant      (grant),
    .digits     (digits),
    .flt_pt     (flt_pt),
    .disp_on    (disp_on)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_sources();
    src_digits = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    src_flt_pt = {8'h08, 8'h04, 8'h02, 8'h01};
  endtask

  task automatic push(input logic [1:0] s);
    exp_t e;
    e.grant  = 4'b0001 << s;
    e.digits = src_digits[s];
    e.flt    = src_flt_pt[s];
    sb.push_back(e);
  endtask

  task automatic do_reset();
    NRST = 1'b0;
    req  = 4'b0000;
    tick();
    tick();
    NRST = 1'b1;
  endtask

  // Monitor: invariants every cycle plus scoreboard pop on each new grant.
  logic [3:0] prev_grant = 4'b0000;
  logic       pending    = 1'b0;
  logic       nrst_edge  = 1'b0;
  logic       own_before = 1'b0;
  exp_t       cur;

  always @(posedge CLK) begin
    nrst_edge  = NRST;
    own_before = |grant;
  end

  always @(negedge CLK) begin
    checks++;
    if (!$onehot0(grant)) $display("[TB] FAIL onehot0: grant=%b", grant);
    else passed++;
    checks++;
    if (!disp_on && (digits !== 32'h0 || flt_pt !== 8'h0))
      $display("[TB] FAIL blank_when_off: digits=%h flt=%h, expected 0", digits, flt_pt);
    else passed++;
    if (nrst_edge) begin
      checks++;
      if (disp_on !== own_before)
        $display("[TB] FAIL disp_on_align: disp_on=%b, expected %b", disp_on, own_before);
      else passed++;
    end
    if (pending) begin
      checks++;
      if (disp_on !== 1'b1 || digits !== cur.digits || flt_pt !== cur.flt)
        $display("[TB] FAIL owner_data: on=%b digits=%h flt=%h, expected on=1 digits=%h flt=%h",
                 disp_on, digits, flt_pt, cur.digits, cur.flt);
      else passed++;
      pending = 1'b0;
    end
    if (grant != 4'b0000 && prev_grant == 4'b0000) begin
      checks++;
      if (sb.size() == 0) begin
        $display("[TB] FAIL sb_unexpected: grant=%b with empty scoreboard", grant);
      end else begin
        cur = sb.pop_front();
        if (grant !== cur.grant)
          $display("[TB] FAIL sb_grant: grant=%b, expected %b", grant, cur.grant);
        else passed++;
        pending = 1'b1;
      end
    end
    prev_grant = grant;
  end

  task automatic test_reset();
    set_sources();
    NRST = 1'b0;
    req  = 4'hF;
    tick();
    tick();
    checks++;
    if (grant !== 4'b0 || digits !== 32'h0 || disp_on !== 1'b0 || flt_pt !== 8'h0)
      $display("[TB] FAIL reset_outputs: grant=%b digits=%h on=%b flt=%h, expected all 0",
               grant, digits, disp_on, flt_pt);
    else passed++;
    push(2'd0);
    NRST = 1'b1;
    tick();
    checks++;
    if (grant !== 4'b0001) $display("[TB] FAIL reset_first_grant: grant=%b, expected 0001", grant);
    else passed++;
    req = 4'b0000;
    repeat (4) tick();
    checks++;
    if (grant !== 4'b0 || disp_on !== 1'b0)
      $display("[TB] FAIL reset_idle: grant=%b on=%b, expected 0000/0", grant, disp_on);
    else passed++;
  endtask

  task automatic test_sole_owner();
    set_sources();
    src_digits[2] = 32'h12345678;
    push(2'd2);
    req = 4'b0100;
    tick();
    checks++;
    if (grant !== 4'b0100 || disp_on !== 1'b0)
      $display("[TB] FAIL sole_grant: grant=%b on=%b, expected 0100/0", grant, disp_on);
    else passed++;
    tick();
    checks++;
    if (digits !== 32'h12345678 || disp_on !== 1'b1)
      $display("[TB] FAIL sole_digits: digits=%h on=%b, expected 12345678/1", digits, disp_on);
    else passed++;
    for (int c = 0; c < 22; c++) begin
      tick();
      checks++;
      if (grant !== 4'b0100 || disp_on !== 1'b1)
        $display("[TB] FAIL sole_hold_%0d: grant=%b on=%b, expected 0100/1", c, grant, disp_on);
      else passed++;
    end
    src_digits[2] = 32'h87654321;
    tick();
    checks++;
    if (digits !== 32'h87654321)
      $display("[TB] FAIL sole_latency: digits=%h, expected 87654321", digits);
    else passed++;
    req = 4'b0000;
    tick();
    checks++;
    if (grant !== 4'b0000) $display("[TB] FAIL sole_release: grant=%b, expected 0000", grant);
    else passed++;
    repeat (3) tick();
    checks++;
    if (digits !== 32'h0 || disp_on !== 1'b0)
      $display("[TB] FAIL sole_blanked: digits=%h on=%b, expected 0/0", digits, disp_on);
    else passed++;
  endtask

  task automatic test_preempt_rr();
    logic [1:0] order [4];
    order = '{2'd0, 2'd1, 2'd3, 2'd0};
    set_sources();
    do_reset();
    for (int k = 0; k < 4; k++) push(order[k]);
    req = 4'b1011;
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 5; c++) begin
        tick();
        checks++;
        if (grant !== (4'b0001 << order[k]))
          $display("[TB] FAIL rr_own_%0d_%0d: grant=%b, expected %b", k, c, grant,
                   4'b0001 << order[k]);
        else passed++;
      end
      if (k < 3) begin
        for (int b = 0; b < 2; b++) begin
          tick();
          checks++;
          if (grant !== 4'b0000)
            $display("[TB] FAIL rr_blank_%0d_%0d: grant=%b, expected 0000", k, b, grant);
          else passed++;
        end
      end
    end
    req = 4'b0000;
    repeat (3) tick();
    checks++;
    if (grant !== 4'b0000) $display("[TB] FAIL rr_idle: grant=%b, expected 0000", grant);
    else passed++;
  endtask

  task automatic test_release();
    set_sources();
    do_reset();
    push(2'd0);
    push(2'd3);
    req = 4'b1001;
    tick();
    checks++;
    if (grant !== 4'b0001) $display("[TB] FAIL rel_first: grant=%b, expected 0001", grant);
    else passed++;
    req = 4'b1000;
    for (int b = 0; b < 2; b++) begin
      tick();
      checks++;
      if (grant !== 4'b0000) $display("[TB] FAIL rel_blank_%0d: grant=%b, expected 0000", b, grant);
      else passed++;
    end
    tick();
    checks++;
    if (grant !== 4'b1000) $display("[TB] FAIL rel_next: grant=%b, expected 1000", grant);
    else passed++;
    req = 4'b0000;
    repeat (4) tick();
  endtask

  task automatic test_simultaneous();
    set_sources();
    do_reset();
    push(2'd0);
    push(2'd1);
    push(2'd2);
    req = 4'b0011;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (grant !== 4'b0001) $display("[TB] FAIL sim_own_%0d: grant=%b, expected 0001", c, grant);
      else passed++;
    end
    req = 4'b0010;
    for (int b = 0; b < 2; b++) begin
      tick();
      checks++;
      if (grant !== 4'b0000) $display("[TB] FAIL sim_blank_%0d: grant=%b, expected 0000", b, grant);
      else passed++;
    end
    tick();
    checks++;
    if (grant !== 4'b0010) $display("[TB] FAIL sim_next: grant=%b, expected 0010", grant);
    else passed++;
    req = 4'b0000;
    repeat (4) tick();
    checks++;
    if (grant !== 4'b0000) $display("[TB] FAIL sim_to_idle: grant=%b, expected 0000", grant);
    else passed++;
    req = 4'b0100;
    tick();
    checks++;
    if (grant !== 4'b0100) $display("[TB] FAIL sim_idle_regrant: grant=%b, expected 0100", grant);
    else passed++;
    req = 4'b0000;
    repeat (4) tick();
  endtask

  task automatic test_reset_mid();
    set_sources();
    do_reset();
    push(2'd1);
    req = 4'b0010;
    tick();
    tick();
    tick();
    NRST = 1'b0;
    req  = 4'b0110;
    tick();
    checks++;
    if (grant !== 4'b0 || digits !== 32'h0 || disp_on !== 1'b0 || flt_pt !== 8'h0)
      $display("[TB] FAIL mid_own_reset: grant=%b digits=%h on=%b flt=%h, expected all 0",
               grant, digits, disp_on, flt_pt);
    else passed++;
    push(2'd1);
    NRST = 1'b1;
    tick();
    checks++;
    if (grant !== 4'b0010) $display("[TB] FAIL mid_own_regrant: grant=%b, expected 0010", grant);
    else passed++;
    req = 4'b0100;
    tick();
    checks++;
    if (grant !== 4'b0000) $display("[TB] FAIL mid_blank_enter: grant=%b, expected 0000", grant);
    else passed++;
    NRST = 1'b0;
    tick();
    checks++;
    if (grant !== 4'b0 || digits !== 32'h0 || disp_on !== 1'b0)
      $display("[TB] FAIL mid_blank_reset: grant=%b digits=%h on=%b, expected all 0",
               grant, digits, disp_on);
    else passed++;
    push(2'd1);
    NRST = 1'b1;
    req  = 4'b1010;
    tick();
    checks++;
    if (grant !== 4'b0010) $display("[TB] FAIL mid_blank_regrant: grant=%b, expected 0010", grant);
    else passed++;
    req = 4'b0000;
    repeat (4) tick();
  endtask

  initial begin
    NRST = 1'b0;
    req  = 4'b0000;
    set_sources();
    test_reset();
    test_sole_owner();
    test_preempt_rr();
    test_release();
    test_simultaneous();
    test_reset_mid();
    repeat (2) tick();
    checks++;
    if (sb.size() != 0) $display("[TB] FAIL sb_leftover: %0d entries, expected 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
